uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART_TX serializer between NUM_REQ byte producers, e.g. a debug console, a status reporter and a loopback of UART_RX output.
- Each requester uses a valid/ready byte interface. A round-robin scheduler picks one requester at a time.
- The block launches the chosen byte into UART_TX with a one-cycle o_TX_DV pulse, then holds off all requesters until UART_TX reports done.
- A watchdog recovers the block if UART_TX never reports done.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CLKS_PER_BIT, 217, clocks per UART bit; must match the UART_TX instance (25 MHz clock, 115200 baud).
- TIMEOUT_CLKS, CLKS_PER_BIT*12, clocks to wait in a WAIT state for i_TX_Done before forcing recovery.

Ports:
- i_Clk  in  1  system clock; all logic on the rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Req_Valid  in  NUM_REQ  bit k high means requester k holds a byte.
- i_Req_Byte  in  NUM_REQ*8  byte for requester k in bits [8k+7:8k].
- o_Req_Ready  out  NUM_REQ  one-cycle acceptance pulse, one-hot.
- o_TX_DV  out  1  one-cycle launch strobe to UART_TX.
- o_TX_Byte  out  8  byte to UART_TX; valid while o_TX_DV is high.
- i_TX_Active  in  1  UART_TX busy.
- i_TX_Done  in  1  UART_TX one-cycle completion pulse.
- o_Grant_ID  out  3  index of the current or last granted requester.
- o_Busy  out  1  high in any state other than IDLE.
- o_Timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous assert, synchronous release): state = IDLE; all outputs = 0; RR pointer = NUM_REQ-1, so requester 0 wins first; watchdog counter = 0.
- Reset mid-transfer abandons the byte. Requesters are not told; they must reissue after reset.
- States: IDLE, WAIT_DONE, plus TAG_WAIT when the tag feature is compiled in.
- IDLE:
  - If i_Req_Valid != 0 and i_TX_Active == 0, pick the winner: the first set bit searching pointer+1, pointer+2, … modulo NUM_REQ.
  - At that edge: latch the winner's byte into o_TX_Byte, set o_Req_Ready[winner], set o_TX_DV, set o_Grant_ID = winner, set pointer = winner, go to WAIT_DONE.
  - Latency from valid sampled to ready/DV high is 1 cycle. ready and DV are high in the same cycle and clear at the next edge.
- If i_TX_Active is high while in IDLE (foreign traffic), hold in IDLE and issue no grants.
- Requester rule: hold i_Req_Valid and the byte stable until o_Req_Ready is seen. During the ready cycle the requester may drop valid or present its next byte.
- WAIT_DONE:
  - The watchdog counts from 0.
  - i_TX_Done is ignored in the cycle o_TX_DV is high.
  - i_TX_Done seen later: go to IDLE, clear the counter.
  - A new grant can be issued on the edge after the return to IDLE, so back-to-back bytes are separated by exactly 1 idle cycle.
  - Counter reaching TIMEOUT_CLKS-1 without done: go to IDLE and pulse o_Timeout. A done arriving on that same edge wins, and no timeout is reported.
- i_TX_Done in IDLE is ignored.
- Requester lockout: a requester that holds valid continuously gets at most one byte per round while others are waiting. With a single active requester, every grant goes to it.
- The priority search must handle every wrap position, including pointer = NUM_REQ-1.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined: every grant first sends tag byte {4'hF, 1'b0, grant_id[2:0]} with the DV pulse.
  - The block then enters TAG_WAIT, which has its own watchdog.
  - On i_TX_Done in TAG_WAIT, it pulses o_TX_DV with the latched data byte the next cycle and enters WAIT_DONE.
  - o_Req_Ready still pulses in the grant cycle, together with the tag DV.
  - A timeout in TAG_WAIT drops the data byte and returns to IDLE.
- Undefined: TAG_WAIT is absent and only data bytes are sent.

Decomposition:
- Package uart_pkg:
  - state encoding typedef;
  - TAG_PREFIX = 4'hF;
  - default CLKS_PER_BIT = 217;
  - function clog2 for the counter width.
- One sub-module, uart_rr_pick: combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reused by future shared-bus blocks.

Test Plan:
- Single request: req1 valid with 0x37 -> ready[1] and o_TX_DV high together 1 cycle later, o_TX_Byte = 0x37; an attached UART_RX receives 0x37; o_Busy falls after i_TX_Done.
- Simultaneous requests: all 4 valid after reset with bytes 0x10..0x13 -> serial order 0x10, 0x11, 0x12, 0x13; grant order 0,1,2,3; exactly 1 idle cycle between done and the next DV.
- Fairness with wrap: req0 and req3 held valid continuously over 6 grants -> grants alternate 0,3,0,3,0,3.
- Watchdog: stub UART_TX that never pulses done -> o_Timeout pulses exactly TIMEOUT_CLKS (2604) cycles after DV; the next grant proceeds normally.
- Reset mid-byte: deassert i_Rst_L during WAIT_DONE -> all outputs 0 immediately; after release, req2 (0xA5) is granted in 1 cycle.
- UART_ARB_TAG_EN defined: req2 sends 0x55 -> serial bytes 0xF2 then 0x55; ready[2] pulses once, with the tag DV.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared state encoding, constants and helpers for uart_tx_arbiter.
// Rev 1.0. State TAG_WAIT exists only when UART_ARB_TAG_EN is defined.
package uart_pkg;

  localparam int         DEF_CLKS_PER_BIT = 217;
  localparam logic [3:0] TAG_PREFIX       = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1
`ifdef UART_ARB_TAG_EN
    , ST_TAG_WAIT = 2'd2
`endif
  } arb_state_t;

  // Width needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// uart_tx_arbiter_if: requester byte channels plus the UART_TX launch/status link.
// Rev 1.0. Modport master is the arbiter side, slave is the producers/UART side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [NUM_REQ*8-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic [2:0]           o_Grant_ID;
  logic                 o_Busy;
  logic                 o_Timeout;

  modport master (
    input  i_Req_Valid, i_Req_Byte, i_TX_Active, i_TX_Done,
    output o_Req_Ready, o_TX_DV, o_TX_Byte, o_Grant_ID, o_Busy, o_Timeout
  );

  modport slave (
    output i_Req_Valid, i_Req_Byte, i_TX_Active, i_TX_Done,
    input  o_Req_Ready, o_TX_DV, o_TX_Byte, o_Grant_ID, o_Busy, o_Timeout
  );
endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// uart_rr_pick: combinational round-robin selector; searches ptr+1, ptr+2, ...
// modulo NUM_REQ and returns the first set request as one-hot, index and any. Rev 1.0
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         idx,
  output logic               any
);

  int                 pos;
  logic [NUM_REQ-1:0] req_rot;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    req_rot = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos     = (int'(ptr) + i) % NUM_REQ;
      req_rot = req >> pos;
      if (!any && req_rot[0]) begin
        any = 1'b1;
        gnt = NUM_REQ'(1) << pos;
        idx = 3'(pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin sharing of one UART_TX among NUM_REQ byte producers,
// with a done watchdog. Define UART_ARB_TAG_EN to prefix each grant with a tag byte. Rev 1.0
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = CLKS_PER_BIT * 12
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  uart_tx_arbiter_if.master  bus
);

  localparam int CW = clog2(TIMEOUT_CLKS);

  arb_state_t         state, next_state;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               dv_q, dv_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`ifdef UART_ARB_TAG_EN
  logic [7:0]         data_q, data_d;
`endif

  logic [NUM_REQ-1:0] pick_gnt;
  logic [2:0]         pick_idx;
  logic               pick_any;
  logic [7:0]         pick_byte;
  logic               wd_expire;
  logic               done_seen;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.i_Req_Valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_byte = bus.i_Req_Byte[8*int'(pick_idx) +: 8];
  assign wd_expire = (cnt_q == CW'(TIMEOUT_CLKS - 1));
  // A done pulse in the launch cycle belongs to earlier traffic, never to this byte.
  assign done_seen = bus.i_TX_Done && !dv_q;

  always_comb begin
    next_state = state;
    tx_byte_d  = tx_byte_q;
    ready_d    = '0;
    dv_d       = 1'b0;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`ifdef UART_ARB_TAG_EN
    data_d     = data_q;
`endif
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_any && !bus.i_TX_Active) begin
          ready_d = pick_gnt;
          dv_d    = 1'b1;
          grant_d = pick_idx;
          ptr_d   = pick_idx;
`ifdef UART_ARB_TAG_EN
          tx_byte_d  = {TAG_PREFIX, 1'b0, pick_idx};
          data_d     = pick_byte;
          next_state = ST_TAG_WAIT;
`else
          tx_byte_d  = pick_byte;
          next_state = ST_WAIT_DONE;
`endif
        end
      end
      ST_WAIT_DONE: begin
        if (done_seen) begin
          next_state = ST_IDLE;
          cnt_d      = '0;
        end else if (wd_expire) begin
          next_state = ST_IDLE;
          cnt_d      = '0;
          timeout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG_WAIT: begin
        if (done_seen) begin
          next_state = ST_WAIT_DONE;
          dv_d       = 1'b1;
          tx_byte_d  = data_q;
          cnt_d      = '0;
        end else if (wd_expire) begin
          next_state = ST_IDLE;
          cnt_d      = '0;
          timeout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        next_state = ST_IDLE;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= ST_IDLE;
      tx_byte_q <= '0;
      ready_q   <= '0;
      dv_q      <= 1'b0;
      grant_q   <= '0;
      ptr_q     <= 3'(NUM_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef UART_ARB_TAG_EN
      data_q    <= '0;
`endif
    end else begin
      state     <= next_state;
      tx_byte_q <= tx_byte_d;
      ready_q   <= ready_d;
      dv_q      <= dv_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`ifdef UART_ARB_TAG_EN
      data_q    <= data_d;
`endif
    end
  end

  assign bus.o_Req_Ready = ready_q;
  assign bus.o_TX_DV     = dv_q;
  assign bus.o_TX_Byte   = tx_byte_q;
  assign bus.o_Grant_ID  = grant_q;
  assign bus.o_Busy      = (state != ST_IDLE);
  assign bus.o_Timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against
// a queue-free round-robin reference model and a simple UART_TX stub.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 2604;
  localparam int BUDGET  = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  logic [N-1:0] rvalid;
  logic [7:0]   rbyte [N];
  logic         tx_active;
  logic         tx_done;
  int           tests;
  int           fails;
  int           ptr_m;

  assign bus.i_Req_Valid = rvalid;
  assign bus.i_TX_Active = tx_active;
  assign bus.i_TX_Done   = tx_done;
  always_comb begin
    bus.i_Req_Byte = '0;
    for (int k = 0; k < N; k++) bus.i_Req_Byte[8*k +: 8] = rbyte[k];
  end

  // Reference rule: first valid requester after the last winner, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 1; i <= N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(output int n);
    n = 0;
    while (bus.o_TX_DV !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    check("dv_seen", {31'd0, bus.o_TX_DV}, 32'd1);
  endtask

  // UART_TX stub: busy for 'hold' cycles after launch, then a done pulse.
  task automatic finish_byte(input int hold);
    tx_active = 1'b1;
    repeat (hold) tick();
    tx_done   = 1'b1;
    tx_active = 1'b0;
    tick();
    tx_done   = 1'b0;
  endtask

  task automatic serve(input int id, input int lat, input int hold, input bit keep);
    int         n;
    logic [7:0] b;
    b = rbyte[id];
    wait_dv(n);
    if (lat >= 0) check("latency", n, lat);
    check("ready_onehot", {28'd0, bus.o_Req_Ready}, 32'd1 << id);
    check("grant_id", {29'd0, bus.o_Grant_ID}, id);
    check("busy_in_grant", {31'd0, bus.o_Busy}, 32'd1);
    ptr_m = id;
    if (keep) rbyte[id] = 8'($urandom);
    else      rvalid[id] = 1'b0;
`ifdef UART_ARB_TAG_EN
    check("tag_byte", {24'd0, bus.o_TX_Byte}, 32'hF0 | id);
    finish_byte(hold);
    check("data_dv", {31'd0, bus.o_TX_DV}, 32'd1);
    check("data_byte", {24'd0, bus.o_TX_Byte}, {24'd0, b});
    check("ready_once", {28'd0, bus.o_Req_Ready}, 32'd0);
`else
    check("tx_byte", {24'd0, bus.o_TX_Byte}, {24'd0, b});
`endif
    finish_byte(hold);
    check("idle_after_done", {31'd0, bus.o_Busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   {28'd0, bus.o_Req_Ready}, 32'd0);
    check({tag, "_dv"},      {31'd0, bus.o_TX_DV}, 32'd0);
    check({tag, "_byte"},    {24'd0, bus.o_TX_Byte}, 32'd0);
    check({tag, "_grant"},   {29'd0, bus.o_Grant_ID}, 32'd0);
    check({tag, "_busy"},    {31'd0, bus.o_Busy}, 32'd0);
    check({tag, "_timeout"}, {31'd0, bus.o_Timeout}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    rvalid    = '0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    for (int k = 0; k < N; k++) rbyte[k] = 8'h00;
    ptr_m = N - 1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int cnt;
    tests = 0;
    fails = 0;

    // Reset state
    do_reset();
    check_all_zero("reset");
    tick();
    check("post_reset_busy", {31'd0, bus.o_Busy}, 32'd0);

    // Single request from requester 1
    rvalid[1] = 1'b1;
    rbyte[1]  = 8'h37;
    serve(1, 1, 3, 1'b0);

    // Done pulse while idle is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_in_idle_busy", {31'd0, bus.o_Busy}, 32'd0);
    check("done_in_idle_dv", {31'd0, bus.o_TX_DV}, 32'd0);

    // All four simultaneous after reset: strict order 0..3, one idle cycle apart
    do_reset();
    for (int k = 0; k < N; k++) begin
      rvalid[k] = 1'b1;
      rbyte[k]  = 8'h10 + 8'(k);
    end
    for (int k = 0; k < N; k++) serve(k, 1, 2 + k, 1'b0);

    // Fairness across the wrap: requesters 0 and 3 held continuously
    rvalid[0] = 1'b1; rbyte[0] = 8'hC0;
    rvalid[3] = 1'b1; rbyte[3] = 8'hC3;
    for (int g = 0; g < 6; g++) serve((g % 2 == 0) ? 0 : 3, 1, 2, 1'b1);
    rvalid = '0;
    tick();

    // Done during the launch cycle must not end the transfer
    rvalid[1] = 1'b1; rbyte[1] = 8'h6B;
    wait_dv(n);
    ptr_m = 1;
    rvalid[1] = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_in_dv_ignored", {31'd0, bus.o_Busy}, 32'd1);
`ifdef UART_ARB_TAG_EN
    finish_byte(2);
`endif
    finish_byte(2);
    check("done_in_dv_finish", {31'd0, bus.o_Busy}, 32'd0);

    // Watchdog: no done ever arrives
    rvalid[2] = 1'b1; rbyte[2] = 8'h5A;
    wait_dv(n);
    ptr_m = 2;
    rvalid[2] = 1'b0;
    cnt = 0;
    while (bus.o_Timeout !== 1'b1 && cnt < TIMEOUT + 20) begin
      tick();
      cnt++;
    end
    check("timeout_delay", cnt, TIMEOUT);
    check("timeout_busy", {31'd0, bus.o_Busy}, 32'd0);
    check("timeout_no_dv", {31'd0, bus.o_TX_DV}, 32'd0);
    tick();
    check("timeout_width", {31'd0, bus.o_Timeout}, 32'd0);

    // Done on the expiry edge wins over the watchdog
    rvalid[3] = 1'b1; rbyte[3] = 8'h9C;
    wait_dv(n);
    ptr_m = 3;
    rvalid[3] = 1'b0;
    repeat (TIMEOUT - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_wins_timeout", {31'd0, bus.o_Timeout}, 32'd0);
`ifdef UART_ARB_TAG_EN
    check("done_wins_data_dv", {31'd0, bus.o_TX_DV}, 32'd1);
    finish_byte(2);
`endif
    check("done_wins_idle", {31'd0, bus.o_Busy}, 32'd0);

    // Randomized traffic against the reference model, with foreign UART traffic
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < N; k++) begin
        if (!rvalid[k] && $urandom_range(0, 1) == 1) begin
          rvalid[k] = 1'b1;
          rbyte[k]  = 8'($urandom);
        end
      end
      if (rvalid == '0) begin
        n = $urandom_range(0, N - 1);
        rvalid[n] = 1'b1;
        rbyte[n]  = 8'($urandom);
      end
      if (r % 5 == 2) begin
        tx_active = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
          tick();
          if (bus.o_TX_DV === 1'b1) cnt++;
        end
        check("foreign_no_grant", cnt, 0);
        tx_active = 1'b0;
      end
      serve(pick(rvalid, ptr_m), 1, $urandom_range(1, 5), 1'($urandom_range(0, 1)));
    end
    rvalid = '0;
    tick();

    // Reset in the middle of a transfer
    rvalid[0] = 1'b1; rbyte[0] = 8'h3E;
    wait_dv(n);
    rvalid[0] = 1'b0;
    tx_active = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    tick();
    tx_active = 1'b0;
    rst_n     = 1'b1;
    ptr_m     = N - 1;
    rvalid[2] = 1'b1;
    rbyte[2]  = 8'hA5;
    serve(2, 1, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_time_limit observed=expired required=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
